cla_serial_adder_ctrl: RTL

//  Multi-cycle sequencer that adds two WIDTH-bit operands 2 bits per clock through one

---
 rtl/cla_pkg.sv | 31 +++
 rtl/cla_carry_generate_2bits.sv | 24 ++
 rtl/cla_pg_chunk_2bits.sv | 40 ++++
 rtl/cla_serial_adder_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared constants and FSM encoding for the serial
//                carry-lookahead adder sequencer.
//                Optional feature macro used by the slice: CLA_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package cla_pkg;

   // Bits consumed per clock by the shared lookahead slice.
   localparam int CLA_CHUNK = 2;

   // Sequencer state encoding (explicit 2-bit width).
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Chunk-counter width: $clog2(WIDTH/2) with a floor of one bit so a
   // single-chunk adder still has a legal counter.
   function automatic int idx_width(input int width);
      int nchunk;
      nchunk = width / CLA_CHUNK;
      if (nchunk <= 1)
         return 1;
      return $clog2(nchunk);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_carry_generate_2bits.sv
`default_nettype none
// ============================================================================
//  Module      : cla_carry_generate_2bits
//  Description : 2-bit carry-lookahead generator. Produces the carry into
//                bit 1 and the carry out of bit 1 directly from p/g/cin.
//  Ports       : p[1:0], g[1:0] - propagate / generate terms (in)
//                cin            - carry into bit 0 (in)
//                c0             - carry into bit 1 (out)
//                c1             - carry out of the 2-bit group (out)
//  Revision    : 1.0  initial release
// ============================================================================
module cla_carry_generate_2bits (
   input  logic [1:0] p,
   input  logic [1:0] g,
   input  logic       cin,
   output logic       c0,
   output logic       c1
);

   assign c0 = g[0] | (p[0] & cin);
   assign c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);

endmodule
`default_nettype wire

// File: rtl/cla_pg_chunk_2bits.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pg_chunk_2bits
//  Description : Purely combinational 2-bit adder chunk: p/g generation, one
//                lookahead carry generator and the sum XORs.
//  Ports       : a[1:0], b[1:0] - operand chunk (in)
//                cin            - carry into the chunk (in)
//                s[1:0]         - chunk sum (out)
//                c0             - carry into the chunk's upper bit (out)
//                c1             - chunk carry-out (out)
//  Revision    : 1.0  initial release
// ============================================================================
module cla_pg_chunk_2bits (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       c0,
   output logic       c1
);

   logic [1:0] w_p;
   logic [1:0] w_g;

   assign w_p = a ^ b;
   assign w_g = a & b;

   cla_carry_generate_2bits u_cgen (
      .p   (w_p),
      .g   (w_g),
      .cin (cin),
      .c0  (c0),
      .c1  (c1)
   );

   assign s[0] = w_p[0] ^ cin;
   assign s[1] = w_p[1] ^ c0;

endmodule
`default_nettype wire

// File: rtl/cla_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cla_serial_adder_ctrl
//  Description : Multi-cycle sequencer adding two WIDTH-bit operands two bits
//                per clock through one shared 2-bit lookahead chunk. Operands
//                are latched on an accepted start, chunks are processed
//                LSB->MSB with a registered ripple carry, and the result is
//                presented registered with a one-cycle done pulse.
//  Config      : CLA_OVF_EN - adds the 'ovf' output (two's-complement
//                overflow, registered with cout).
//  Ports       : clk, rst (async, active-high)
//                start        - request, accepted only while ready=1
//                a, b, cin    - operands, sampled on accepted start
//                ready        - IDLE or DONE
//                busy         - RUN
//                done         - one-cycle result-valid pulse
//                sum, cout    - registered result, held until next accept
//                ovf          - (CLA_OVF_EN only) signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module cla_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   import cla_pkg::*;

   localparam int NCHUNK = WIDTH / CLA_CHUNK;
   localparam int IDXW   = idx_width(WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
         $error("cla_serial_adder_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   state_t           r_state;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_done;
`ifdef CLA_OVF_EN
   logic             r_ovf;
`endif

   // Bit offset of the current chunk: idx*2.
   logic [IDXW:0]    w_lo;
   logic [1:0]       w_a2;
   logic [1:0]       w_b2;
   logic [1:0]       w_s2;
   logic             w_c0;
   logic             w_c1;
   logic             w_accept;

   assign w_lo = {r_idx, 1'b0};
   assign w_a2 = r_a[w_lo +: 2];
   assign w_b2 = r_b[w_lo +: 2];

   cla_pg_chunk_2bits u_chunk (
      .a   (w_a2),
      .b   (w_b2),
      .cin (r_carry),
      .s   (w_s2),
      .c0  (w_c0),
      .c1  (w_c1)
   );

   // start is only honoured while ready; in RUN it is ignored entirely.
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_done  <= 1'b0;
`ifdef CLA_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         // done is a single-cycle pulse, even when a new add is accepted
         // straight out of DONE.
         r_done <= 1'b0;
         case (r_state)
            ST_RUN: begin
               r_sum[w_lo +: 2] <= w_s2;
               r_carry          <= w_c1;
               r_idx            <= r_idx + 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_cout  <= w_c1;
`ifdef CLA_OVF_EN
                  // In the last chunk c0 is the carry into the MSB.
                  r_ovf   <= w_c0 ^ w_c1;
`endif
               end
            end
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  // sum/cout are intentionally left untouched here; they
                  // keep the previous result until overwritten chunk-wise.
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign busy  = (r_state == ST_RUN);
   assign done  = r_done;
   assign sum   = r_sum;
   assign cout  = r_cout;
`ifdef CLA_OVF_EN
   assign ovf   = r_ovf;
`endif

endmodule
`default_nettype wire
